// File: rtl/data_mem_resp_pkg.sv
// Shared constants and types for the MEM-stage data responder.
package data_mem_resp_pkg;

    // Cache control bus layout: {memValid, memWrite, size[1:0], unsignedLd}
    localparam int unsigned DataCacheControlBus = 5;
    localparam int unsigned MemValidBit         = 4;
    localparam int unsigned MemWriteBit         = 3;
    localparam int unsigned MemSizeHi           = 2;
    localparam int unsigned MemSizeLo           = 1;
    localparam int unsigned MemUnsignedBit      = 0;

    // Access size codes; 2'b11 is reserved and behaves as a word access
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    // Width of the wait-state counter (WAIT_CYCLES <= 15)
    localparam int unsigned CntW = 4;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

endpackage

// File: rtl/data_ram_bank.sv
// Word-organised data RAM: synchronous byte-enabled write, asynchronous read.
module data_ram_bank #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    logic [31:0] mem_q [Depth];

    // Byte-lane write; contents are intentionally not reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_resp.sv
// Responder end of the MEM-stage data interface: executes loads/stores against
// an internal RAM, models SRAM wait states and stalls the pipeline while busy.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DataCacheControlBus-1:0] dataCacheControlIn,
    input  logic [31:0]                    addrIn,
    input  logic [31:0]                    storeDataIn,
    input  logic                           writeEnableIn,
    input  logic [4:0]                     writeBackAddrIn,
    output logic [31:0]                    dataOut,
    output logic                           writeEnableOut,
    output logic [4:0]                     writeBackAddrOut,
    output logic                           stallOut,
    output logic                           misalignOut
);

    localparam logic [CntW-1:0] WaitInit = CntW'(WAIT_CYCLES);

    state_e                         state_q, state_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic [DataCacheControlBus-1:0] hold_ctrl_q, hold_ctrl_d;
    logic [31:0]                    hold_addr_q, hold_addr_d;
    logic [31:0]                    hold_sd_q, hold_sd_d;
    logic                           hold_we_q, hold_we_d;
    logic [4:0]                     hold_rd_q, hold_rd_d;
    logic [31:0]                    data_q, data_d;
    logic                           we_q, we_d;
    logic [4:0]                     rd_q, rd_d;
    logic                           mis_q, mis_d;

    logic                           in_idle;
    logic                           in_misaligned;
    logic                           commit;
    logic [DataCacheControlBus-1:0] acc_ctrl;
    logic [31:0]                    acc_addr;
    logic [31:0]                    acc_sd;
    logic                           acc_we;
    logic [4:0]                     acc_rd;
    logic [1:0]                     acc_size;
    logic [1:0]                     acc_off;
    logic [1:0]                     in_size;
    logic [3:0]                     lane_be;
    logic [3:0]                     ram_be;
    logic [31:0]                    ram_wdata;
    logic [31:0]                    ram_rdata;
    logic [31:0]                    rd_shift;
    logic [31:0]                    load_data;

    assign in_idle = (state_q == StIdle);

    // In IDLE the live inputs are accessed directly (zero-wait commit); in BUSY the captured copy
    assign acc_ctrl = in_idle ? dataCacheControlIn : hold_ctrl_q;
    assign acc_addr = in_idle ? addrIn             : hold_addr_q;
    assign acc_sd   = in_idle ? storeDataIn        : hold_sd_q;
    assign acc_we   = in_idle ? writeEnableIn      : hold_we_q;
    assign acc_rd   = in_idle ? writeBackAddrIn    : hold_rd_q;
    assign acc_size = acc_ctrl[MemSizeHi:MemSizeLo];
    assign acc_off  = acc_addr[1:0];

    assign in_size       = dataCacheControlIn[MemSizeHi:MemSizeLo];
    assign in_misaligned = ((in_size == SizeHalf) && addrIn[0]) ||
                           (in_size[1] && (addrIn[1:0] != 2'b00));

    // Byte enables and lane-replicated store data
    always_comb begin
        lane_be   = 4'b1111;
        ram_wdata = acc_sd;
        if (acc_size == SizeByte) begin
            lane_be   = 4'b0001 << acc_off;
            ram_wdata = {4{acc_sd[7:0]}};
        end else if (acc_size == SizeHalf) begin
            lane_be   = acc_off[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{acc_sd[15:0]}};
        end
    end

    assign ram_be = (commit && acc_ctrl[MemWriteBit]) ? lane_be : 4'b0000;

    data_ram_bank #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  (acc_addr[ADDR_BITS+1:2]),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Load lane select and sign/zero extension
    always_comb begin
        rd_shift = ram_rdata >> {acc_off, 3'b000};
        if (acc_size == SizeByte) begin
            load_data = acc_ctrl[MemUnsignedBit] ? {24'h0, rd_shift[7:0]}
                                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
        end else if (acc_size == SizeHalf) begin
            load_data = acc_ctrl[MemUnsignedBit] ? {16'h0, rd_shift[15:0]}
                                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
        end else begin
            load_data = ram_rdata;
        end
    end

    // FSM next state, request capture and result path
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_ctrl_d = hold_ctrl_q;
        hold_addr_d = hold_addr_q;
        hold_sd_d   = hold_sd_q;
        hold_we_d   = hold_we_q;
        hold_rd_d   = hold_rd_q;
        data_d      = data_q;
        we_d        = we_q;
        rd_d        = rd_q;
        mis_d       = 1'b0;
        commit      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!dataCacheControlIn[MemValidBit]) begin
                    data_d = addrIn;
                    we_d   = writeEnableIn;
                    rd_d   = writeBackAddrIn;
                end else if (in_misaligned) begin
                    mis_d  = 1'b1;
                    we_d   = 1'b0;
                    data_d = addrIn;
                    rd_d   = writeBackAddrIn;
                end else if (WAIT_CYCLES == 0) begin
                    commit = 1'b1;
                end else begin
                    hold_ctrl_d = dataCacheControlIn;
                    hold_addr_d = addrIn;
                    hold_sd_d   = storeDataIn;
                    hold_we_d   = writeEnableIn;
                    hold_rd_d   = writeBackAddrIn;
                    cnt_d       = WaitInit;
                    state_d     = StBusy;
                    we_d        = 1'b0;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                we_d  = 1'b0;
                if (cnt_q == CntW'(1)) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (commit) begin
            rd_d = acc_rd;
            if (acc_ctrl[MemWriteBit]) begin
                data_d = acc_addr;
                we_d   = 1'b0;
            end else begin
                data_d = load_data;
                we_d   = acc_we;
            end
        end
    end

    // State, holding and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_ctrl_q <= '0;
            hold_addr_q <= '0;
            hold_sd_q   <= '0;
            hold_we_q   <= 1'b0;
            hold_rd_q   <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_ctrl_q <= hold_ctrl_d;
            hold_addr_q <= hold_addr_d;
            hold_sd_q   <= hold_sd_d;
            hold_we_q   <= hold_we_d;
            hold_rd_q   <= hold_rd_d;
            data_q      <= data_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            mis_q       <= mis_d;
        end
    end

    assign stallOut         = (state_q == StBusy);
    assign dataOut          = data_q;
    assign writeEnableOut   = we_q;
    assign writeBackAddrOut = rd_q;
    assign misalignOut      = mis_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: three instances (WAIT_CYCLES 0, 1, 3)
// share stimulus; one is selected at a time for checking.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ctrl = '0;
    logic [31:0] addr = '0;
    logic [31:0] sd = '0;
    logic        we = 1'b0;
    logic [4:0]  rd = '0;

    logic [31:0] d0, d1, d3;
    logic        w0, w1, w3;
    logic [4:0]  r0, r1, r3;
    logic        s0, s1, s3;
    logic        m0, m1, m3;

    int          sel = 1;
    logic [31:0] o_data;
    logic        o_we;
    logic [4:0]  o_rd;
    logic        o_stall;
    logic        o_mis;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        we;
        logic [4:0]  rd;
        logic        chk_rd;
        logic        mis;
        string       name;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    data_mem_resp #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .dataCacheControlIn(ctrl), .addrIn(addr), .storeDataIn(sd),
        .writeEnableIn(we), .writeBackAddrIn(rd), .dataOut(d0), .writeEnableOut(w0),
        .writeBackAddrOut(r0), .stallOut(s0), .misalignOut(m0)
    );
    data_mem_resp #(.ADDR_BITS(10), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .dataCacheControlIn(ctrl), .addrIn(addr), .storeDataIn(sd),
        .writeEnableIn(we), .writeBackAddrIn(rd), .dataOut(d1), .writeEnableOut(w1),
        .writeBackAddrOut(r1), .stallOut(s1), .misalignOut(m1)
    );
    data_mem_resp #(.ADDR_BITS(10), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .dataCacheControlIn(ctrl), .addrIn(addr), .storeDataIn(sd),
        .writeEnableIn(we), .writeBackAddrIn(rd), .dataOut(d3), .writeEnableOut(w3),
        .writeBackAddrOut(r3), .stallOut(s3), .misalignOut(m3)
    );

    always_comb begin
        o_data = d1; o_we = w1; o_rd = r1; o_stall = s1; o_mis = m1;
        case (sel)
            0: begin o_data = d0; o_we = w0; o_rd = r0; o_stall = s0; o_mis = m0; end
            3: begin o_data = d3; o_we = w3; o_rd = r3; o_stall = s3; o_mis = m3; end
            default: ;
        endcase
    end

    // Monitor: every edge that leaves the selected DUT idle carries one response
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && !o_stall) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    $display("FAIL unexpected_resp: got data=%h we=%b rd=%0d mis=%b, required none",
                             o_data, o_we, o_rd, o_mis);
                end else begin
                    e = sbq.pop_front();
                    if (o_data === e.data && o_we === e.we && o_mis === e.mis &&
                        (!e.chk_rd || o_rd === e.rd)) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s: got data=%h we=%b rd=%0d mis=%b, required data=%h we=%b rd=%0d mis=%b",
                                 e.name, o_data, o_we, o_rd, o_mis, e.data, e.we, e.rd, e.mis);
                    end
                end
            end
        end
    end

    // Drive one request, queue its expected response and check its stall length
    task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] s,
                         input logic w, input logic [4:0] r, input logic [31:0] edata,
                         input logic ewe, input logic chkrd, input logic emis,
                         input int estall, input string name);
        exp_t e;
        int   n;
        @(negedge clk);
        ctrl = c; addr = a; sd = s; we = w; rd = r;
        e.data = edata; e.we = ewe; e.rd = r; e.chk_rd = chkrd; e.mis = emis; e.name = name;
        sbq.push_back(e);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (o_stall && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (n == estall) n_pass++;
        else $display("FAIL %s_stall: got %0d cycles, required %0d", name, n, estall);
    endtask

    // Quiesce all instances with NOPs, then select another one for checking
    task automatic switch_to(input int new_sel);
        @(negedge clk);
        mon_en = 1'b0;
        ctrl = '0; addr = '0; we = 1'b0; rd = '0;
        repeat (6) @(negedge clk);
        sel = new_sel;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset: outputs must be zero even with live inputs toggling
        addr = 32'hFFFF; we = 1'b1; rd = 5'd31; ctrl = 5'h00;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            sel = (k == 2) ? 3 : k;
            #1;
            n_checks++;
            if (o_data == 32'h0 && o_we == 1'b0 && o_rd == 5'd0 && !o_stall && !o_mis) n_pass++;
            else $display("FAIL reset_sel%0d: got data=%h we=%b rd=%0d stall=%b mis=%b, required all 0",
                          sel, o_data, o_we, o_rd, o_stall, o_mis);
        end
        @(negedge clk);
        ctrl = '0; addr = '0; we = 1'b0; rd = '0;
        rst = 1'b0;
        sel = 1;

        // WAIT_CYCLES = 1
        issue(5'h1C, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0, 32'h10, 1'b0, 1'b0, 1'b0, 1, "sw_10");
        issue(5'h14, 32'h10, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1, "lw_10");
        issue(5'h1C, 32'h20, 32'h0, 1'b0, 5'd0, 32'h20, 1'b0, 1'b0, 1'b0, 1, "sw_20");
        issue(5'h18, 32'h23, 32'hFFFFFF80, 1'b0, 5'd0, 32'h23, 1'b0, 1'b0, 1'b0, 1, "sb_23");
        issue(5'h10, 32'h23, 32'h0, 1'b1, 5'd6, 32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 1, "lb_23");
        issue(5'h11, 32'h23, 32'h0, 1'b1, 5'd6, 32'h00000080, 1'b1, 1'b1, 1'b0, 1, "lbu_23");
        issue(5'h14, 32'h20, 32'h0, 1'b1, 5'd8, 32'h80000000, 1'b1, 1'b1, 1'b0, 1, "lw_20");
        issue(5'h1A, 32'h32, 32'h12348001, 1'b0, 5'd0, 32'h32, 1'b0, 1'b0, 1'b0, 1, "sh_32");
        issue(5'h12, 32'h32, 32'h0, 1'b1, 5'd10, 32'hFFFF8001, 1'b1, 1'b1, 1'b0, 1, "lh_32");
        issue(5'h13, 32'h32, 32'h0, 1'b1, 5'd11, 32'h00008001, 1'b1, 1'b1, 1'b0, 1, "lhu_32");
        issue(5'h12, 32'h33, 32'h0, 1'b1, 5'd7, 32'h33, 1'b0, 1'b0, 1'b1, 0, "lh_33_mis");
        issue(5'h13, 32'h32, 32'h0, 1'b1, 5'd12, 32'h00008001, 1'b1, 1'b1, 1'b0, 1, "lhu_32_again");
        issue(5'h14, 32'h22, 32'h0, 1'b1, 5'd13, 32'h22, 1'b0, 1'b0, 1'b1, 0, "lw_22_mis");
        issue(5'h1C, 32'h1000, 32'hCAFE0001, 1'b0, 5'd0, 32'h1000, 1'b0, 1'b0, 1'b0, 1, "sw_1000");
        issue(5'h14, 32'h0, 32'h0, 1'b1, 5'd14, 32'hCAFE0001, 1'b1, 1'b1, 1'b0, 1, "lw_0_wrap");

        // WAIT_CYCLES = 0: store then immediate loads see new data
        switch_to(0);
        issue(5'h1C, 32'h84, 32'h0BADF00D, 1'b0, 5'd0, 32'h84, 1'b0, 1'b0, 1'b0, 0, "w0_sw_84");
        issue(5'h11, 32'h85, 32'h0, 1'b1, 5'd1, 32'h000000F0, 1'b1, 1'b1, 1'b0, 0, "w0_lbu_85");
        issue(5'h12, 32'h86, 32'h0, 1'b1, 5'd2, 32'h00000BAD, 1'b1, 1'b1, 1'b0, 0, "w0_lh_86");
        issue(5'h10, 32'h84, 32'h0, 1'b1, 5'd3, 32'h0000000D, 1'b1, 1'b1, 1'b0, 0, "w0_lb_84");
        issue(5'h18, 32'h87, 32'h000000FF, 1'b0, 5'd0, 32'h87, 1'b0, 1'b0, 1'b0, 0, "w0_sb_87");
        issue(5'h14, 32'h84, 32'h0, 1'b1, 5'd4, 32'hFFADF00D, 1'b1, 1'b1, 1'b0, 0, "w0_lw_84");

        // WAIT_CYCLES = 3
        switch_to(3);
        issue(5'h1C, 32'h60, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h60, 1'b0, 1'b0, 1'b0, 3, "w3_sw_60");
        issue(5'h14, 32'h60, 32'h0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 3, "w3_lw_60");
        issue(5'h00, 32'h1234, 32'h0, 1'b1, 5'd9, 32'h1234, 1'b1, 1'b1, 1'b0, 0, "w3_nonmem");
        issue(5'h1C, 32'h40, 32'h22222222, 1'b0, 5'd0, 32'h40, 1'b0, 1'b0, 1'b0, 3, "w3_sw_40");

        // Abort a store with reset in its second busy cycle
        @(negedge clk);
        mon_en = 1'b0;
        ctrl = 5'h1C; addr = 32'h40; sd = 32'h11111111; we = 1'b0; rd = 5'd0;
        @(posedge clk);
        #1;
        n_checks++;
        if (o_stall) n_pass++;
        else $display("FAIL abort_accept: got stall=%b, required 1", o_stall);
        @(posedge clk);
        #2;
        rst = 1'b1;
        ctrl = '0; addr = '0;
        #1;
        n_checks++;
        if (o_data == 32'h0 && !o_we && o_rd == 5'd0 && !o_stall && !o_mis) n_pass++;
        else $display("FAIL abort_reset: got data=%h we=%b rd=%0d stall=%b mis=%b, required all 0",
                      o_data, o_we, o_rd, o_stall, o_mis);
        @(negedge clk);
        rst = 1'b0;
        issue(5'h14, 32'h40, 32'h0, 1'b1, 5'd3, 32'h22222222, 1'b1, 1'b1, 1'b0, 3, "w3_lw_40_old");

        @(negedge clk);
        mon_en = 1'b0;
        n_checks++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d pending, required 0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
